generic_mem_writer: RTL and testbench

- Writer-side counterpart of the team's synchronous-read memories.
- Accepts a valid/ready byte stream and packs bytes little-endian into DATA_WIDTH words.
- Writes each word to a single-port memory write interface at sequential addresses from a programmable base.
- Used to load ROM/RAM images at run time, in place of file-based initialisation.

---
 rtl/generic_mem_writer.sv | 153 +++++++++++++++
 tb/tb_generic_mem_writer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/generic_mem_writer.sv
// Packs a little-endian byte stream into DATA_WIDTH words and writes them to sequential addresses.
// Optional readback check of every word is enabled with `define GENERIC_MEM_WRITER_VERIFY_EN.
module generic_mem_writer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [ADDRESS_WIDTH-1:0] i_base_addr,
  input  logic [ADDRESS_WIDTH:0]   i_word_count,
  input  logic                     i_byte_valid,
  input  logic [7:0]               i_byte_data,
  output logic                     o_byte_ready,
  output logic [ADDRESS_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0]    o_mem_write_data,
  output logic                     o_mem_write_en,
  input  logic [DATA_WIDTH-1:0]    i_mem_read_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [ADDRESS_WIDTH:0]   o_words_written,
  output logic                     o_verify_error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    WRITE    = 3'd2,
    RD_ADDR  = 3'd3,
    RD_CHECK = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t                 state_reg;
  logic [IDX_W-1:0]       byte_idx_reg;
  logic [ADDRESS_WIDTH:0] count_reg;
  logic [ADDRESS_WIDTH:0] words_next;
  logic                   last_word;
  logic                   verify_error_reg;
  logic [BYTES-1:0]       lane_hit;

  assign words_next = o_words_written + (ADDRESS_WIDTH + 1)'(1);
  assign last_word  = (words_next == count_reg);

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign lane_hit[gi] = (byte_idx_reg == IDX_W'(gi));
    end
  endgenerate

`ifdef GENERIC_MEM_WRITER_VERIFY_EN
  assign o_verify_error = verify_error_reg;
`else
  logic unused_read_data;
  assign unused_read_data = ^i_mem_read_data;
  assign o_verify_error   = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg        <= IDLE;
      byte_idx_reg     <= '0;
      count_reg        <= '0;
      verify_error_reg <= 1'b0;
      o_byte_ready     <= 1'b0;
      o_mem_address    <= '0;
      o_mem_write_data <= '0;
      o_mem_write_en   <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_words_written  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            o_mem_address    <= i_base_addr;
            count_reg        <= i_word_count;
            o_words_written  <= '0;
            verify_error_reg <= 1'b0;
            byte_idx_reg     <= '0;
            o_busy           <= 1'b1;
            if (i_word_count == '0) begin
              state_reg <= DONE;
              o_done    <= 1'b1;
            end else begin
              state_reg    <= FILL;
              o_byte_ready <= 1'b1;
            end
          end
        end
        FILL: begin
          if (i_byte_valid && o_byte_ready) begin
            for (int i = 0; i < BYTES; i++) begin
              if (lane_hit[i]) o_mem_write_data[8*i +: 8] <= i_byte_data;
            end
            if (byte_idx_reg == LAST_IDX) begin
              byte_idx_reg   <= '0;
              o_byte_ready   <= 1'b0;
              o_mem_write_en <= 1'b1;
              state_reg      <= WRITE;
            end else begin
              byte_idx_reg <= byte_idx_reg + IDX_W'(1);
            end
          end
        end
        WRITE: begin
          o_mem_write_en <= 1'b0;
`ifdef GENERIC_MEM_WRITER_VERIFY_EN
          state_reg <= RD_ADDR;
`else
          o_words_written <= words_next;
          o_mem_address   <= o_mem_address + ADDRESS_WIDTH'(1);
          if (last_word) begin
            state_reg <= DONE;
            o_done    <= 1'b1;
          end else begin
            state_reg    <= FILL;
            o_byte_ready <= 1'b1;
          end
`endif
        end
`ifdef GENERIC_MEM_WRITER_VERIFY_EN
        // Address is held here so the memory registers the read of the word just written.
        RD_ADDR: state_reg <= RD_CHECK;
        RD_CHECK: begin
          if (i_mem_read_data != o_mem_write_data) verify_error_reg <= 1'b1;
          o_words_written <= words_next;
          o_mem_address   <= o_mem_address + ADDRESS_WIDTH'(1);
          if (last_word) begin
            state_reg <= DONE;
            o_done    <= 1'b1;
          end else begin
            state_reg    <= FILL;
            o_byte_ready <= 1'b1;
          end
        end
`endif
        DONE: begin
          o_done    <= 1'b0;
          o_busy    <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_generic_mem_writer.sv
// Directed and randomized bench for generic_mem_writer with a memory model and a queue-based reference.
module tb_generic_mem_writer;
  localparam int AW = 8;
  localparam int DW = 32;
`ifdef GENERIC_MEM_WRITER_VERIFY_EN
  localparam logic VERIFY = 1'b1;
`else
  localparam logic VERIFY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] rd_data_reg;
  logic          busy;
  logic          done;
  logic [AW:0]   words_written;
  logic          verify_error;

  always #5 clk = ~clk;

  generic_mem_writer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_word_count(word_count), .i_byte_valid(byte_valid), .i_byte_data(byte_data),
    .o_byte_ready(byte_ready), .o_mem_address(mem_addr), .o_mem_write_data(mem_wdata),
    .o_mem_write_en(mem_we), .i_mem_read_data(rd_data_reg), .o_busy(busy), .o_done(done),
    .o_words_written(words_written), .o_verify_error(verify_error)
  );

  // Synchronous-read memory; optionally corrupts the readback of one address.
  logic [DW-1:0] mem [0:255];
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    rd_data_reg <= mem[mem_addr] ^ ((corrupt_en && mem_addr == corrupt_addr) ? 32'h0000_0100 : 32'h0);
  end

  // Monitor sampled 1 time unit after the active edge.
  logic [AW-1:0] obs_addr[$];
  logic [DW-1:0] obs_data[$];
  int done_cnt = 0, strobe_viol = 0, ready_viol = 0, run_len = 0;
  always @(posedge clk) begin
    #1;
    if (mem_we) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
      run_len = run_len + 1;
      if (run_len > 1) strobe_viol = strobe_viol + 1;
      if (byte_ready) ready_viol = ready_viol + 1;
    end else begin
      run_len = 0;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  int total = 0, bad = 0;
  logic [7:0] stim[$];
  int obs0, d0, sv0, rv0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_xfer(input logic [AW-1:0] base, input logic [AW:0] count);
    obs0 = obs_addr.size(); d0 = done_cnt; sv0 = strobe_viol; rv0 = ready_viol;
    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = count;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: valid held high, 1: pattern 1,0,0,1, 2: random
  task automatic feed(input int mode, input int first, input int last);
    int idx = first;
    int cyc = 0;
    logic v;
    while (idx < last && cyc < 2000) begin
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      byte_valid = v;
      byte_data  = stim[idx];
      if (v && byte_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    byte_valid = 1'b0;
    check("feed accepted all bytes", 64'(idx), 64'(last));
  endtask

  task automatic finish_xfer(input string tag, input logic [AW-1:0] base, input int count);
    int n = 0;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done pulses"}, 64'(done_cnt - d0), 64'd1);
    check({tag, " busy in done"}, 64'(busy), 64'd1);
    check({tag, " words_written"}, 64'(words_written), 64'(count));
    check({tag, " write count"}, 64'(obs_addr.size() - obs0), 64'(count));
    check({tag, " single-cycle strobes"}, 64'(strobe_viol - sv0), 64'd0);
    check({tag, " ready low in write"}, 64'(ready_viol - rv0), 64'd0);
    for (int w = 0; w < count; w++) begin
      ea = base + AW'(w);
      ed = {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]};
      if (obs0 + w < obs_addr.size()) begin
        check($sformatf("%s addr[%0d]", tag, w), 64'(obs_addr[obs0+w]), 64'(ea));
        check($sformatf("%s data[%0d]", tag, w), 64'(obs_data[obs0+w]), 64'(ed));
      end
    end
  endtask

  task automatic set_stim8();
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(negedge clk);
    check("reset ready", 64'(byte_ready), 64'd0);
    check("reset addr", 64'(mem_addr), 64'd0);
    check("reset wdata", 64'(mem_wdata), 64'd0);
    check("reset we", 64'(mem_we), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset words", 64'(words_written), 64'd0);
    check("reset verr", 64'(verify_error), 64'd0);
    rst_n = 1'b1;

    set_stim8();
    start_xfer(8'h10, 9'd2);
    feed(0, 0, 8);
    finish_xfer("basic", 8'h10, 2);
    $display("txn basic: base=10 count=2");

    // Starts in the cycle right after o_done.
    start_xfer(8'h10, 9'd2);
    feed(1, 0, 8);
    finish_xfer("stall b2b", 8'h10, 2);
    $display("txn stall back-to-back: base=10 count=2");

    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0a, 8'h0b, 8'h0c};
    start_xfer(8'hFF, 9'd3);
    feed(0, 0, 12);
    finish_xfer("wrap", 8'hFF, 3);
    $display("txn wrap: base=ff count=3");

    start_xfer(8'h20, 9'd0);
    check("zero done next cycle", 64'(done), 64'd1);
    finish_xfer("zero", 8'h20, 0);
    $display("txn zero count: base=20");

    stim = '{8'h01, 8'h02, 8'h03, 8'h04};
    start_xfer(8'h30, 9'd1);
    feed(0, 0, 2);
    rst_n = 1'b0;
    #1;
    check("midrst ready", 64'(byte_ready), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst addr", 64'(mem_addr), 64'd0);
    check("midrst wdata", 64'(mem_wdata), 64'd0);
    check("midrst we", 64'(mem_we), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("midrst no write", 64'(obs_addr.size() - obs0), 64'd0);
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    start_xfer(8'h30, 9'd1);
    feed(0, 0, 4);
    finish_xfer("after reset", 8'h30, 1);
    $display("txn reset mid-word then base=30 count=1");

    set_stim8();
    start_xfer(8'h40, 9'd2);
    feed(0, 0, 2);
    start = 1'b1; base_addr = 8'h80; word_count = 9'd1;
    @(negedge clk);
    start = 1'b0;
    feed(0, 2, 8);
    finish_xfer("start busy", 8'h40, 2);
    $display("txn start while busy: base=40 count=2");

    set_stim8();
    stim.push_back(8'h99); stim.push_back(8'h9a); stim.push_back(8'h9b); stim.push_back(8'h9c);
    corrupt_en = 1'b1; corrupt_addr = 8'h51;
    start_xfer(8'h50, 9'd3);
    feed(0, 0, 4);
    repeat (3) @(negedge clk);
    check("verify clean word0", 64'(verify_error), 64'd0);
    feed(0, 4, 12);
    finish_xfer("verify", 8'h50, 3);
    check("verify err at done", 64'(verify_error), 64'(VERIFY));
    corrupt_en = 1'b0;
    start_xfer(8'h60, 9'd0);
    check("verify err cleared", 64'(verify_error), 64'd0);
    finish_xfer("verify clr", 8'h60, 0);
    $display("txn verify: base=50 count=3 corrupt=51");

    for (int r = 0; r < 4; r++) begin
      logic [AW-1:0] rb;
      int rc;
      rb = AW'($urandom_range(0, 255));
      rc = $urandom_range(1, 4);
      stim.delete();
      for (int i = 0; i < rc * 4; i++) stim.push_back(8'($urandom));
      start_xfer(rb, (AW+1)'(rc));
      feed(2, 0, rc * 4);
      finish_xfer($sformatf("rand%0d", r), rb, rc);
      $display("txn random %0d: base=%0h count=%0d", r, rb, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
